time_uart_tx: RTL and testbench
===============================

Name: time_uart_tx

Overview:
- Reader/transmitter on the far side of the clock's BCD time outputs.
- On a request pulse, snapshots the six BCD digits (HH:MM:SS) and sends them as ASCII text "HH:MM:SS\r\n" over a single UART TX line (8N1, LSB first).
- Sits beside the clock counters in the top level, on the same clock and reset, and feeds a board UART pin for host logging.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; DIV = (CLK_HZ + BAUD/2) / BAUD clock cycles per bit. Constraint: DIV >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- send  input  1  request; sampled every cycle, accepted only when idle.
- sec_low_bcd  input  4  seconds ones digit.
- sec_high_bcd  input  3  seconds tens digit.
- min_low_bcd  input  4  minutes ones digit.
- min_high_bcd  input  3  minutes tens digit.
- hr_low_bcd  input  4  hours ones digit.
- hr_high_bcd  input  2  hours tens digit.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high from the cycle after acceptance until the frame completes.
- done  output  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset values: tx=1, busy=0, done=0. Sequencer is IDLE, byte index=0, baud and bit counters=0.
- Acceptance: send=1 while IDLE at edge k.
  - All six digits are latched at edge k.
  - busy=1 and tx=0 (start bit) from edge k.
  - Later changes to the digit inputs do not affect the frame.
- Byte sequence, 10 bytes with no inter-byte gap: hr_high, hr_low, ':'(0x3A), min_high, min_low, ':', sec_high, sec_low, CR(0x0D), LF(0x0A).
- Digit encoding: value 0-9 is sent as 0x30+value. Any value >9 (e.g. hr_low=4'hC) is sent as '?' (0x3F). Narrow fields are zero-extended first.
- Bit timing:
  - Each byte is start(0), d0..d7 LSB first, stop(1).
  - Each bit is held exactly DIV cycles.
  - The stop bit of byte n is followed directly by the start bit of byte n+1.
  - Full frame = 100*DIV cycles.
- Sequencer FSM states:
  - IDLE -> START on accept.
  - START -> DATA after DIV cycles.
  - DATA: 8 bits, DIV cycles each, then -> STOP.
  - STOP: after DIV cycles, -> START if byte index < 9, with index incremented.
  - STOP with index = 9 -> IDLE, with done=1 and busy=0 on that same edge.
- send while busy: ignored, no queuing.
- send on the cycle done=1: accepted, since the block is IDLE. The next frame starts one cycle after the previous stop bit ends.
- Reset mid-frame: at the reset edge tx=1, busy=0, done=0, and the frame is abandoned. No partial resume after reset deasserts.
- send and rst both high: reset wins, nothing is accepted.
- Counters:
  - Baud counter width is clog2(DIV); it wraps at DIV-1.
  - Bit counter is 0..7.
  - Byte index is 4 bits, 0..9.

Decomposition:
- Shared package time_uart_pkg holds:
  - ASCII constants: ZERO 0x30, COLON 0x3A, QMARK 0x3F, CR 0x0D, LF 0x0A.
  - FRAME_LEN = 10.
  - Sequencer state enum: IDLE, START, DATA, STOP.
  - A function mapping a 4-bit BCD value to an ASCII byte.
- Sub-module uart_byte_tx is the single-byte serializer. It has inputs clk, rst, start, data[7:0] and outputs tx, ready; it is parameterised by DIV.
- The top level owns the snapshot registers, byte index and byte mux, and generates done.

Test Plan:
- Use CLK_HZ=1_000_000 and BAUD=100_000 (DIV=10) throughout.
- Time 12:34:56, 1-cycle send:
  - tx falls one edge after the send edge.
  - Decoded bytes are 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x0D 0x0A.
  - done pulses exactly 1000 cycles after acceptance; busy is 0 afterwards.
- Snapshot: digits change from 12:34:56 to 23:59:59 at cycle 50 of the frame -> frame still decodes as "12:34:56\r\n".
- send held high continuously for 2500 cycles:
  - Exactly 3 frames are accepted, with each new start bit 1 cycle after done.
  - No send is accepted mid-frame.
- Invalid digits hr_low=4'hA, sec_low=4'hF -> bytes 2 and 8 are 0x3F; all other bytes are correct.
- rst asserted for 1 cycle at frame cycle 437:
  - tx=1, busy=0 from the next edge, and done never pulses.
  - A new send afterwards produces a complete, correct frame.
- Boundary value 23:59:59, then 00:00:00 on a second request -> "23:59:59\r\n" then "00:00:00\r\n". Each bit's width is measured as exactly 10 cycles.

Source files
------------

// File: rtl/time_uart_pkg.sv
// Shared constants, sequencer states, snapshot layout and BCD-to-ASCII helper
// for the time-of-day UART transmitter.
package time_uart_pkg;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  localparam int unsigned FRAME_LEN = 10;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} seq_state_e;

  typedef struct packed {
    logic [1:0] hr_high;
    logic [3:0] hr_low;
    logic [2:0] min_high;
    logic [3:0] min_low;
    logic [2:0] sec_high;
    logic [3:0] sec_low;
  } time_snap_t;

  // Digits above 9 are not valid BCD and go out as '?'.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] v);
    return (v > 4'd9) ? QMARK : 8'(ZERO + {4'b0000, v});
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 single-byte serializer; a start request in the last stop-bit cycle
// chains the next byte with no idle gap.
module uart_byte_tx
  import time_uart_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = data;
          cnt_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (start) begin
            state_d = START;
            tx_d    = 1'b0;
            shift_d = data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/time_uart_tx.sv
// Snapshots the BCD time on request and streams "HH:MM:SS\r\n" over a UART line.
module time_uart_tx
  import time_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [3:0] sec_low_bcd,
  input  logic [2:0] sec_high_bcd,
  input  logic [3:0] min_low_bcd,
  input  logic [2:0] min_high_bcd,
  input  logic [3:0] hr_low_bcd,
  input  logic [1:0] hr_high_bcd,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned      DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  time_snap_t       snap_q, snap_d, live_c;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ser_start_c, ser_ready_c;
  logic [7:0]       ser_data_c;

  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input time_snap_t t);
    logic [7:0] b;
    case (idx)
      4'd0:    b = bcd_to_ascii({2'b00, t.hr_high});
      4'd1:    b = bcd_to_ascii(t.hr_low);
      4'd2:    b = COLON;
      4'd3:    b = bcd_to_ascii({1'b0, t.min_high});
      4'd4:    b = bcd_to_ascii(t.min_low);
      4'd5:    b = COLON;
      4'd6:    b = bcd_to_ascii({1'b0, t.sec_high});
      4'd7:    b = bcd_to_ascii(t.sec_low);
      4'd8:    b = CR;
      default: b = LF;
    endcase
    return b;
  endfunction

  assign live_c = {hr_high_bcd, hr_low_bcd, min_high_bcd, min_low_bcd,
                   sec_high_bcd, sec_low_bcd};
  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // The first byte comes straight from the live inputs since the snapshot
  // only becomes visible one cycle after acceptance.
  always_comb begin
    snap_d      = snap_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ser_start_c = 1'b0;
    ser_data_c  = frame_byte(IDX_W'(0), live_c);
    if (!busy_q) begin
      if (send) begin
        snap_d      = live_c;
        idx_d       = '0;
        busy_d      = 1'b1;
        ser_start_c = 1'b1;
      end
    end else if (ser_ready_c) begin
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d       = idx_q + IDX_W'(1);
        ser_start_c = 1'b1;
        ser_data_c  = frame_byte(idx_q + IDX_W'(1), snap_q);
      end
    end
  end

  uart_byte_tx #(.DIV(DIV)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (ser_start_c),
    .data  (ser_data_c),
    .tx    (tx),
    .ready (ser_ready_c)
  );

endmodule

// File: tb/tb_time_uart_tx.sv
// Scoreboard bench: stimulus queues hand-computed bytes, a UART monitor
// decodes the line and checks every byte and its bit shape.
module tb_time_uart_tx;

  logic       clk = 1'b0;
  logic       rst, send;
  logic [3:0] sec_low_bcd, min_low_bcd, hr_low_bcd;
  logic [2:0] sec_high_bcd, min_high_bcd;
  logic [1:0] hr_high_bcd;
  logic       tx, busy, done;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  time_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk          (clk),
    .rst          (rst),
    .send         (send),
    .sec_low_bcd  (sec_low_bcd),
    .sec_high_bcd (sec_high_bcd),
    .min_low_bcd  (min_low_bcd),
    .min_high_bcd (min_high_bcd),
    .hr_low_bcd   (hr_low_bcd),
    .hr_high_bcd  (hr_high_bcd),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                          input int s1, input int s0);
    hr_high_bcd  = 2'(h1);
    hr_low_bcd   = 4'(h0);
    min_high_bcd = 3'(m1);
    min_low_bcd  = 4'(m0);
    sec_high_bcd = 3'(s1);
    sec_low_bcd  = 4'(s0);
  endtask

  task automatic push_bytes(input logic [79:0] v);
    for (int i = 0; i < 10; i++) exp_q.push_back(v[79-8*i -: 8]);
  endtask

  // One-cycle request, then checks start-bit timing and done latency.
  task automatic run_frame(input string name, input int chg_at);
    int n;
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk({name, "_start_tx"}, tx, 1'b0);
    chk({name, "_start_busy"}, busy, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == chg_at) set_time(2, 3, 5, 9, 5, 9);
    end
    chk({name, "_done_latency"}, n, 1000);
    chk({name, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 1'b0);
  endtask

  // Line monitor: 100 one-cycle samples per byte, sampled just after each edge.
  initial begin : monitor
    logic       smp [100];
    int         n;
    logic [7:0] b;
    logic       shape_ok;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1) begin
        n = 0;
        exp_q.delete();
      end else if (n > 0 || tx === 1'b0) begin
        smp[n] = tx;
        n++;
        if (n == 100) begin
          n = 0;
          shape_ok = 1'b1;
          for (int i = 0; i < 10; i++)
            for (int j = 1; j < 10; j++)
              if (smp[i*10+j] !== smp[i*10]) shape_ok = 1'b0;
          if (smp[0] !== 1'b0 || smp[90] !== 1'b1) shape_ok = 1'b0;
          for (int i = 0; i < 8; i++) b[i] = smp[(i+1)*10 + 5];
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", b);
          end else begin
            chk("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
            chk("bit_shape", shape_ok, 1'b1);
          end
        end
      end
    end
  end

  initial begin : stim
    int n, rises, dones;
    logic prev_busy, prev_done;
    rst  = 1'b1;
    send = 1'b0;
    set_time(1, 2, 3, 4, 5, 6);
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;

    push_bytes(80'h31_32_3A_33_34_3A_35_36_0D_0A);
    run_frame("basic", 0);

    set_time(1, 2, 3, 4, 5, 6);
    push_bytes(80'h31_32_3A_33_34_3A_35_36_0D_0A);
    run_frame("snapshot", 50);

    // Request held high: back-to-back frames, one cycle apart.
    set_time(1, 2, 3, 4, 5, 6);
    repeat (3) push_bytes(80'h31_32_3A_33_34_3A_35_36_0D_0A);
    rises = 0;
    dones = 0;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    @(negedge clk);
    send = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) rises++;
      if (done) dones++;
      if (prev_done) begin
        chk("hold_restart_tx", tx, 1'b0);
        chk("hold_restart_busy", busy, 1'b1);
      end
      prev_busy = busy;
      prev_done = done;
    end
    send = 1'b0;
    chk("hold_accepts", rises, 3);
    chk("hold_dones", dones, 2);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("hold_final_done", done, 1'b1);
    @(negedge clk);

    set_time(1, 4'hA, 3, 4, 5, 4'hF);
    push_bytes(80'h31_3F_3A_33_34_3A_35_3F_0D_0A);
    run_frame("invalid", 0);

    // Reset in the middle of the fifth byte.
    set_time(1, 2, 3, 4, 5, 6);
    push_bytes(80'h31_32_3A_33_34_3A_35_36_0D_0A);
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (437) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_idle_tx", tx, 1'b1);
    push_bytes(80'h31_32_3A_33_34_3A_35_36_0D_0A);
    run_frame("after_rst", 0);

    // Reset and request together: reset wins.
    rst  = 1'b1;
    send = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    send = 1'b0;
    @(negedge clk);
    chk("rst_send_busy", busy, 1'b0);
    chk("rst_send_tx", tx, 1'b1);

    set_time(2, 3, 5, 9, 5, 9);
    push_bytes(80'h32_33_3A_35_39_3A_35_39_0D_0A);
    run_frame("max_time", 0);
    set_time(0, 0, 0, 0, 0, 0);
    push_bytes(80'h30_30_3A_30_30_3A_30_30_0D_0A);
    run_frame("zero_time", 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
